// File: rtl/psram_qpi_responder_if.sv
// Controller-to-device signal bundle for one x4 QPI PSRAM die.
interface psram_qpi_responder_if;
    logic       i_psram_sclk;
    logic       i_psram_csn;
    logic [3:0] i_psram_dq;
    logic [3:0] o_psram_dq;
    logic       o_psram_dq_oe;
    logic       o_qpi_mode;
    logic       o_err;

    modport master (
        output i_psram_sclk, i_psram_csn, i_psram_dq,
        input  o_psram_dq, o_psram_dq_oe, o_qpi_mode, o_err
    );

    modport slave (
        input  i_psram_sclk, i_psram_csn, i_psram_dq,
        output o_psram_dq, o_psram_dq_oe, o_qpi_mode, o_err
    );
endinterface

// File: rtl/psram_qpi_responder.sv
// Device-side x4 QPI PSRAM model: 35h enter-QPI, EBh quad read, 38h quad write, oversampled SCLK.
// Define PSRAM_RSP_BURST_EN for wrapping multi-byte bursts; default is one byte per transaction.
module psram_qpi_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic                  i_clk,
    input  logic                  arst_n,
    psram_qpi_responder_if.slave  psram
);
    localparam logic [2:0] ST_CMD    = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_WDATA  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       csn_s1, csn_s2;
    logic [3:0] dq_s1, dq_s2, dq_s3;
    logic       rise, fall;

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  cmd_sr;
    logic [23:0] addr;
    logic        rd;
    logic        phase;
    logic [3:0]  wr_hi;
    logic [7:0]  rd_byte;
    logic [3:0]  dq_q;
    logic        oe_q;
    logic        qpi_q;
    logic        err_q;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] spi_byte;
    logic [7:0] qpi_byte;
    logic [7:0] mem_cur;
    logic       mem_we;

    // Only the low ADDR_W bits select a byte; the rest alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[23:20];

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            csn_s1  <= 1'b1; csn_s2  <= 1'b1;
            dq_s1   <= '0;   dq_s2   <= '0;   dq_s3   <= '0;
        end else begin
            sclk_s1 <= psram.i_psram_sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            csn_s1  <= psram.i_psram_csn;  csn_s2  <= csn_s1;
            dq_s1   <= psram.i_psram_dq;   dq_s2   <= dq_s1;   dq_s3   <= dq_s2;
        end
    end

    assign rise     = sclk_s2 & ~sclk_s3;
    assign fall     = ~sclk_s2 & sclk_s3;
    assign spi_byte = {cmd_sr[6:0], dq_s3[0]};
    assign qpi_byte = {cmd_sr[7:4], dq_s3};
    assign mem_cur  = mem[addr[ADDR_W-1:0]];
    assign mem_we   = ~csn_s2 & rise & (state == ST_WDATA) & phase;

`ifdef PSRAM_RSP_BURST_EN
    logic [ADDR_W-1:0] addr_inc;
    logic [7:0]        mem_nxt;
    assign addr_inc = addr[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign mem_nxt  = mem[addr_inc];
`endif

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[addr[ADDR_W-1:0]] <= {wr_hi, dq_s3};
    end

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ST_CMD;
            cnt     <= '0;
            cmd_sr  <= '0;
            addr    <= '0;
            rd      <= 1'b0;
            phase   <= 1'b0;
            wr_hi   <= '0;
            rd_byte <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            qpi_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // Deselect outranks any SCLK edge seen in the same cycle.
            if (csn_s2) begin
                state <= ST_CMD;
                cnt   <= '0;
                phase <= 1'b0;
                oe_q  <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: if (rise) begin
                        if (!qpi_q) begin
                            cmd_sr <= spi_byte;
                            cnt    <= cnt + 8'd1;
                            if (cnt == 8'd7) begin
                                cnt   <= '0;
                                state <= ST_IGNORE;
                                if (spi_byte == 8'h35) qpi_q <= 1'b1;
                                else                   err_q <= 1'b1;
                            end
                        end else if (cnt == 8'd0) begin
                            cmd_sr[7:4] <= dq_s3;
                            cnt         <= 8'd1;
                        end else begin
                            cnt <= '0;
                            case (qpi_byte)
                                8'hEB:   begin rd <= 1'b1; state <= ST_ADDR; end
                                8'h38:   begin rd <= 1'b0; state <= ST_ADDR; end
                                default: begin err_q <= 1'b1; state <= ST_IGNORE; end
                            endcase
                        end
                    end
                    ST_ADDR: if (rise) begin
                        addr <= {addr[19:0], dq_s3};
                        cnt  <= cnt + 8'd1;
                        if (cnt == 8'd5) begin
                            cnt   <= '0;
                            phase <= 1'b0;
                            state <= rd ? ST_WAIT : ST_WDATA;
                        end
                    end
                    ST_WAIT: begin
                        if (rise) begin
                            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                        end else if (fall && cnt == 8'(WAIT_CYCLES)) begin
                            rd_byte <= mem_cur;
                            dq_q    <= mem_cur[7:4];
                            oe_q    <= 1'b1;
                            phase   <= 1'b0;
                            state   <= ST_RDATA;
                        end
                    end
                    ST_RDATA: if (fall) begin
                        if (!phase) begin
                            dq_q  <= rd_byte[3:0];
                            phase <= 1'b1;
                        end else begin
`ifdef PSRAM_RSP_BURST_EN
                            addr[ADDR_W-1:0] <= addr_inc;
                            rd_byte          <= mem_nxt;
                            dq_q             <= mem_nxt[7:4];
                            phase            <= 1'b0;
`else
                            oe_q  <= 1'b0;
                            state <= ST_IGNORE;
`endif
                        end
                    end
                    ST_WDATA: if (rise) begin
                        if (!phase) begin
                            wr_hi <= dq_s3;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
`ifdef PSRAM_RSP_BURST_EN
                            addr[ADDR_W-1:0] <= addr_inc;
`else
                            state <= ST_IGNORE;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign psram.o_psram_dq    = dq_q;
    assign psram.o_psram_dq_oe = oe_q;
    assign psram.o_qpi_mode    = qpi_q;
    assign psram.o_err         = err_q;
endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: mode entry, write/read, aliasing, abort, reset, bursts.
module tb_psram_qpi_responder;
    localparam int HALF = 8;

    logic i_clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   err_cnt = 0;

    psram_qpi_responder_if bus();

    psram_qpi_responder #(.ADDR_W(10), .WAIT_CYCLES(6)) dut (
        .i_clk (i_clk),
        .arst_n(arst_n),
        .psram (bus)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (bus.o_err === 1'b1) err_cnt <= err_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] d, output logic [3:0] q, output logic oe);
        bus.i_psram_dq = d;
        repeat (HALF) @(negedge i_clk);
        q  = bus.o_psram_dq;
        oe = bus.o_psram_dq_oe;
        bus.i_psram_sclk = 1'b1;
        repeat (HALF) @(negedge i_clk);
        bus.i_psram_sclk = 1'b0;
    endtask

    task automatic cs_on();
        bus.i_psram_csn = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic cs_off();
        bus.i_psram_csn = 1'b1;
        repeat (6) @(negedge i_clk);
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        logic [3:0] q; logic o;
        cs_on();
        for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]}, q, o);
        cs_off();
    endtask

    task automatic qpi_hdr(input logic [7:0] cmd, input logic [23:0] a, input int nnib);
        logic [3:0] q; logic o;
        cs_on();
        pulse(cmd[7:4], q, o);
        pulse(cmd[3:0], q, o);
        for (int i = 0; i < nnib; i++) pulse(a[23-4*i -: 4], q, o);
    endtask

    // dat holds up to three bytes, first byte in dat[23:16]
    task automatic wr_xact(input logic [23:0] a, input logic [23:0] dat, input int nb);
        logic [3:0] q; logic o;
        qpi_hdr(8'h38, a, 6);
        for (int i = 0; i < 2*nb; i++) pulse(dat[23-4*i -: 4], q, o);
        cs_off();
    endtask

    task automatic rd_open(input logic [23:0] a);
        logic [3:0] q; logic o;
        qpi_hdr(8'hEB, a, 6);
        for (int i = 0; i < 6; i++) pulse(4'h0, q, o);
    endtask

    task automatic rd_byte(output logic [7:0] b, output logic oe_hi, output logic oe_lo);
        logic [3:0] q1, q2;
        pulse(4'h0, q1, oe_hi);
        pulse(4'h0, q2, oe_lo);
        b = {q1, q2};
    endtask

    initial begin
        logic [7:0] b;
        logic       oh, ol, o;
        logic [3:0] q;
        int         e0;

        bus.i_psram_sclk = 1'b0;
        bus.i_psram_csn  = 1'b1;
        bus.i_psram_dq   = 4'h0;
        repeat (3) @(negedge i_clk);
        chk("rst_dq",   bus.o_psram_dq,    4'h0);
        chk("rst_oe",   bus.o_psram_dq_oe, 1'b0);
        chk("rst_mode", bus.o_qpi_mode,    1'b0);
        chk("rst_err",  bus.o_err,         1'b0);
        arst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        e0 = err_cnt;
        spi_cmd(8'h12);
        chk("spi12_err",  err_cnt - e0,   1);
        chk("spi12_mode", bus.o_qpi_mode, 1'b0);

        e0 = err_cnt;
        spi_cmd(8'h35);
        chk("spi35_mode", bus.o_qpi_mode, 1'b1);
        chk("spi35_err",  err_cnt - e0,   0);

        wr_xact(24'h000010, 24'hA5_0000, 1);
        rd_open(24'h000010);
        pulse(4'h0, q, o); chk("rd_hi", q, 4'hA); chk("rd_hi_oe", o, 1'b1);
        pulse(4'h0, q, o); chk("rd_lo", q, 4'h5); chk("rd_lo_oe", o, 1'b1);
        pulse(4'h0, q, o); chk("rd_end_oe", o, 1'b0);
        cs_off();

        wr_xact(24'h000410, 24'h3C_0000, 1);
        rd_open(24'h000010);
        rd_byte(b, oh, ol);
        chk("alias", b, 8'h3C);
        cs_off();

        qpi_hdr(8'h38, 24'h000010, 3);
        cs_off();
        rd_open(24'h000010);
        rd_byte(b, oh, ol);
        chk("abort_keep", b, 8'h3C);
        cs_off();

        rd_open(24'h000010);
        repeat (4) @(negedge i_clk);
        chk("desel_pre_oe", bus.o_psram_dq_oe, 1'b1);
        bus.i_psram_csn = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("desel_oe", bus.o_psram_dq_oe, 1'b0);
        cs_off();

        e0 = err_cnt;
        cs_on();
        pulse(4'h3, q, o);
        pulse(4'h5, q, o);
        cs_off();
        chk("qpi35_err",  err_cnt - e0,   1);
        chk("qpi35_mode", bus.o_qpi_mode, 1'b1);

        wr_xact(24'h0003FF, 24'h112233, 3);
        rd_open(24'h0003FF);
        rd_byte(b, oh, ol);
        chk("burst_b0", b, 8'h11);
`ifdef PSRAM_RSP_BURST_EN
        rd_byte(b, oh, ol);
        chk("burst_b1", b, 8'h22);
        chk("burst_b1_oe", oh, 1'b1);
        rd_byte(b, oh, ol);
        chk("burst_b2", b, 8'h33);
        cs_off();
        rd_open(24'h000001);
        rd_byte(b, oh, ol);
        chk("wrap_001", b, 8'h33);
        cs_off();
`else
        pulse(4'h0, q, o); chk("single_end_oe", o, 1'b0);
        pulse(4'h0, q, o); chk("single_extra_oe", o, 1'b0);
        cs_off();
`endif

        rd_open(24'h000010);
        repeat (4) @(negedge i_clk);
        chk("mid_oe", bus.o_psram_dq_oe, 1'b1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_dq",   bus.o_psram_dq,    4'h0);
        chk("mid_rst_oe",   bus.o_psram_dq_oe, 1'b0);
        chk("mid_rst_mode", bus.o_qpi_mode,    1'b0);
        chk("mid_rst_err",  bus.o_err,         1'b0);
        @(negedge i_clk);
        bus.i_psram_csn  = 1'b1;
        bus.i_psram_sclk = 1'b0;
        repeat (2) @(negedge i_clk);
        arst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        spi_cmd(8'h35);
        chk("post_rst_mode", bus.o_qpi_mode, 1'b1);
        rd_open(24'h000010);
        rd_byte(b, oh, ol);
        chk("post_rst_rd", b, 8'h3C);
        cs_off();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
